// File: rtl/tt_sweep_ctrl_pkg.sv
//============================================================================
// Module : tt_sweep_ctrl_pkg
// Shared state encoding and sizing constants for the truth-table sweeper.
// Rev    : 1.0
//============================================================================
`default_nettype none

package tt_sweep_ctrl_pkg;

  localparam int IDX_W  = 5;
  localparam int N_COMB = 32;

  // Bit i is f(i) for i = {X,Y,Z,K,M}, X as MSB.
  localparam logic [N_COMB-1:0] GOLDEN_DEFAULT = 32'h0AAE_8D5D;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/tt_sweep_ctrl_if.sv
//============================================================================
// Module : tt_sweep_ctrl_if
// Control, function-drive and result bundle between board side and sweeper.
// Rev    : 1.0
//============================================================================
`default_nettype none

interface tt_sweep_ctrl_if;
  import tt_sweep_ctrl_pkg::*;

  logic              start;
  logic              hold;
  logic              f_in;
  logic              x_o;
  logic              y_o;
  logic              z_o;
  logic              k_o;
  logic              m_o;
  logic              busy;
  logic              done;
  logic [N_COMB-1:0] tt;
  logic [IDX_W:0]    ones;
  logic              pass;
  logic [IDX_W-1:0]  err_idx;
  logic              err_any;

  // Board / function side
  modport master (
    output start, hold, f_in,
    input  x_o, y_o, z_o, k_o, m_o, busy, done, tt, ones, pass, err_idx, err_any
  );

  // Sweeper side
  modport slave (
    input  start, hold, f_in,
    output x_o, y_o, z_o, k_o, m_o, busy, done, tt, ones, pass, err_idx, err_any
  );

endinterface

`default_nettype wire

// File: rtl/tt_settle_cnt.sv
//============================================================================
// Module : tt_settle_cnt
// Loadable settle down-counter with hold and zero flag.
// Rev    : 1.0
//============================================================================
`default_nettype none

module tt_settle_cnt #(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_hold,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int            CW     = $clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0] c_load = CW'(SETTLE_CYC - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_hold) begin
      if (i_load) begin
        r_cnt <= c_load;
      end else if (i_dec && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/tt_sweep_ctrl.sv
//============================================================================
// Module : tt_sweep_ctrl
// Sweeps all 32 minterm inputs, captures the truth table and checks it.
// Rev    : 1.0
//============================================================================
`default_nettype none

module tt_sweep_ctrl
  import tt_sweep_ctrl_pkg::*;
#(
  parameter int                SETTLE_CYC = 2,
  parameter logic [N_COMB-1:0] GOLDEN     = GOLDEN_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  tt_sweep_ctrl_if.slave bus
);

  localparam logic [IDX_W-1:0] c_last = IDX_W'(N_COMB - 1);

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_err_idx;
  logic [N_COMB-1:0] r_tt;
  logic [IDX_W:0]    r_ones;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_err_any;

  logic [N_COMB-1:0] w_tt_next;
  logic              w_start_ok;
  logic              w_load;
  logic              w_cnt_zero;

  assign w_start_ok = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_load     = w_start_ok || ((r_state == ST_SAMPLE) && (r_idx != c_last));

  tt_settle_cnt #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_hold (bus.hold),
    .i_load (w_load),
    .i_dec  (r_state == ST_SETTLE),
    .o_zero (w_cnt_zero)
  );

  always_comb begin
    w_tt_next        = r_tt;
    w_tt_next[r_idx] = bus.f_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_tt      <= '0;
      r_ones    <= '0;
      r_pass    <= 1'b0;
      r_err_idx <= '0;
      r_err_any <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // done is a single-cycle pulse even if hold is raised right after it
      r_done <= 1'b0;
      if (!bus.hold) begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (bus.start) begin
              r_state   <= ST_SETTLE;
              r_idx     <= '0;
              r_tt      <= '0;
              r_ones    <= '0;
              r_pass    <= 1'b0;
              r_err_idx <= '0;
              r_err_any <= 1'b0;
              r_busy    <= 1'b1;
            end
          end
          ST_SETTLE: begin
            if (w_cnt_zero) begin
              r_state <= ST_SAMPLE;
            end
          end
          ST_SAMPLE: begin
            r_tt   <= w_tt_next;
            r_ones <= r_ones + {{IDX_W{1'b0}}, bus.f_in};
            if ((bus.f_in != GOLDEN[r_idx]) && !r_err_any) begin
              r_err_idx <= r_idx;
              r_err_any <= 1'b1;
            end
            if (r_idx == c_last) begin
              r_state <= ST_DONE;
              r_pass  <= (w_tt_next == GOLDEN);
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_SETTLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.x_o     = r_idx[4];
  assign bus.y_o     = r_idx[3];
  assign bus.z_o     = r_idx[2];
  assign bus.k_o     = r_idx[1];
  assign bus.m_o     = r_idx[0];
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.tt      = r_tt;
  assign bus.ones    = r_ones;
  assign bus.pass    = r_pass;
  assign bus.err_idx = r_err_idx;
  assign bus.err_any = r_err_any;

endmodule

`default_nettype wire
